// File: rtl/filter_stream_ctrl_if.sv
// Pixel stream bundle: valid/ready handshake with greyscale data and frame markers.
// The master drives the beat; the slave returns ready.
interface filter_stream_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;

    modport master (output valid, data, sop, eop, input ready);
    modport slave  (input valid, data, sop, eop, output ready);
endinterface

// File: rtl/filter_stream_ctrl.sv
// Frame-aligned brighten filter for the VGA pixel stream: one-deep output register,
// mode toggles that take effect only at start-of-frame, and framing/counter bookkeeping.
module filter_stream_ctrl #(
    parameter int DATA_W     = 8,
    parameter int BRIGHT_OFS = 50,
    parameter int PIX_CNT_W  = 19,
    parameter int FRM_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 toggle_req,
    filter_stream_ctrl_if.slave  in_s,
    filter_stream_ctrl_if.master out_s,
    output logic                 mode_active,
    output logic [PIX_CNT_W-1:0] pix_count,
    output logic [FRM_CNT_W-1:0] frame_count,
    output logic                 frame_err
);

    typedef enum logic {
        S_IDLE,
        S_IN_FRAME
    } state_t;

    state_t               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic                 out_sop_q, out_sop_d;
    logic                 out_eop_q, out_eop_d;
    logic                 mode_q, mode_d;
    logic                 pending_q, pending_d;
    logic [PIX_CNT_W-1:0] pix_q, pix_d;
    logic [FRM_CNT_W-1:0] frm_q, frm_d;
    logic                 err_q, err_d;
    logic                 accept;
    logic                 beat_mode;

    // Sum is one bit wider than the pixel so overflow shows up in the top bit.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] x);
        logic [DATA_W:0] sum;
        sum = {1'b0, x} + (DATA_W + 1)'(BRIGHT_OFS);
        return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    endfunction

    assign in_s.ready = !out_valid_q || out_s.ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        mode_d      = mode_q;
        pending_d   = pending_q ^ toggle_req;
        pix_d       = pix_q;
        frm_d       = frm_q;
        err_d       = err_q;
        accept      = in_s.valid && in_s.ready;
        // The SOP beat already runs in the mode the new frame will use.
        beat_mode   = in_s.sop ? (mode_q ^ pending_q) : mode_q;

        if (out_s.ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_mode ? sat_add(in_s.data) : in_s.data;
            out_sop_d   = in_s.sop;
            out_eop_d   = in_s.eop;

            if (in_s.sop) begin
                mode_d    = beat_mode;
                pending_d = toggle_req;
                pix_d     = PIX_CNT_W'(1);
                if (state_q == S_IN_FRAME) begin
                    err_d = 1'b1;
                end
            end else if (state_q == S_IN_FRAME) begin
                if (pix_q != {PIX_CNT_W{1'b1}}) begin
                    pix_d = pix_q + PIX_CNT_W'(1);
                end
            end else begin
                err_d = 1'b1;
            end

            if (in_s.eop) begin
                frm_d   = frm_q + FRM_CNT_W'(1);
                state_d = S_IDLE;
            end else if (in_s.sop) begin
                state_d = S_IN_FRAME;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            mode_q      <= 1'b0;
            pending_q   <= 1'b0;
            pix_q       <= '0;
            frm_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            mode_q      <= mode_d;
            pending_q   <= pending_d;
            pix_q       <= pix_d;
            frm_q       <= frm_d;
            err_q       <= err_d;
        end
    end

    assign out_s.valid = out_valid_q;
    assign out_s.data  = out_data_q;
    assign out_s.sop   = out_sop_q;
    assign out_s.eop   = out_eop_q;
    assign mode_active = mode_q;
    assign pix_count   = pix_q;
    assign frame_count = frm_q;
    assign frame_err   = err_q;

endmodule
